add_sub_serial_unit: RTL

ADD_SUB_SERIAL_UNIT -- requirements
Module: add_sub_serial_unit

---
 rtl/add_sub_pkg.sv | 13 +
 rtl/add_sub_digit.sv | 22 ++
 rtl/add_sub_serial_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// Shared types for the digit-serial adder/subtractor: FSM state encoding and mode constants.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_digit.sv
// One DIGIT-wide slice adder; also exposes the carry into its top bit so the
// caller can derive signed overflow on the most significant slice.
module add_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum   = total[DIGIT-1:0];
  assign cout  = total[DIGIT];
  // A sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out directly.
  assign cmsb  = a[DIGIT-1] ^ b[DIGIT-1] ^ total[DIGIT-1];

endmodule

// File: rtl/add_sub_serial_unit.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes;
// processes DIGIT bits per cycle, LSB slice first, result registered on entry to DONE.
module add_sub_serial_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout,
  output logic             o_Ovf,
  output logic             o_Zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [DIGIT-1:0]  slice_a;
  logic [DIGIT-1:0]  slice_b;
  logic [DIGIT-1:0]  slice_sum;
  logic              slice_cout;
  logic              slice_cmsb;

  assign slice_a = a_q[int'(idx_q)*DIGIT +: DIGIT];
  assign slice_b = b_q[int'(idx_q)*DIGIT +: DIGIT];

  add_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .cmsb (slice_cmsb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          // Subtraction is A + ~B + 1: invert B once here and seed the carry.
          a_d     = i_A;
          b_d     = (i_Mode == MODE_SUB) ? ~i_B : i_B;
          carry_d = (i_Mode == MODE_SUB);
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[int'(idx_q)*DIGIT +: DIGIT] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = res_d;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          zero_d  = (res_d == '0);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_Sum   = sum_q;
  assign o_Cout  = cout_q;
  assign o_Ovf   = ovf_q;
  assign o_Zero  = zero_q;

endmodule
